lfsr_sched: RTL and testbench
=============================

# lfsr_sched

Shared pseudo-random word server: one Fibonacci LFSR time-shared among NREQ requesters by a round-robin arbiter. For each granted request the controller advances the LFSR STEPS times, then returns the resulting word to the winner with a one-cycle grant pulse. It also owns seeding of the LFSR, including the all-zero lock-up guard. It sits between the random-number consumers and the LFSR state register, so no consumer drives the shift register directly.

## Interface
- WIDTH, 8, LFSR and data width (≥3)
- TAP_MASK, 8'hB8, feedback taps; bit i set means state[i] is XORed into the feedback
- NREQ, 4, number of requesters (2..8)
- STEPS, 8, LFSR shifts per delivered word (≥1)
- SEED_DEFAULT, 8'h01, reset value and zero-seed substitute; must be nonzero
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- seed_load  input  1  load seed into the LFSR at the next edge
- seed  input  WIDTH  seed value, sampled when seed_load=1
- req  input  NREQ  per-requester request level, held until gnt
- gnt  output  NREQ  one-hot grant pulse, one cycle, qualifies rdata
- rdata  output  WIDTH  delivered word; holds its last value between grants
- busy  output  1  high in SHIFT and DELIVER

## Operation
- LFSR shift: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)}. The LFSR shifts only in SHIFT.
- FSM states: IDLE, SHIFT, DELIVER.
- IDLE:
  - With req≠0, pick the winner as the first set req bit scanning upward from ptr, wrapping modulo NREQ.
  - Latch the winner, set cnt=STEPS-1, go to SHIFT.
  - With req=0, stay in IDLE.
- SHIFT: shift every cycle. When cnt==0, go to DELIVER; otherwise decrement cnt.
- DELIVER:
  - gnt[winner]=1 and rdata=lfsr, both registered outputs valid this cycle.
  - ptr <= (winner+1) mod NREQ, then go to IDLE.
- A grant is issued even if req[winner] dropped during SHIFT. The word is consumed and ptr advances.
- seed_load has top priority in every state:
  - The LFSR loads seed, or SEED_DEFAULT if seed==0.
  - In IDLE: the request is not arbitrated that cycle. Arbitration happens on the next IDLE cycle.
  - In SHIFT: the transaction aborts. No gnt, ptr and rdata unchanged, go to IDLE.
  - In DELIVER: the grant completes normally and the load takes effect at the same edge.
- Reset values: state=IDLE, lfsr=SEED_DEFAULT, ptr=0, cnt=0, gnt=0, rdata=0, busy=0.
- Async reset mid-transaction drops everything immediately, with no grant.
- Round-robin guarantees that a requester holding req is served within NREQ transactions.

## Timing
- Request path:
  - req sampled high in IDLE at cycle k.
  - SHIFT during cycles k+1..k+STEPS.
  - gnt/rdata valid in cycle k+STEPS+1.
  - IDLE in cycle k+STEPS+2.
- Throughput: one word per STEPS+2 cycles under continuous request.
- busy rises in cycle k+1 and falls in cycle k+STEPS+2.
- seed_load at the edge ending cycle j gives the new lfsr value in cycle j+1.
- gnt is never asserted for more than one consecutive cycle for the same transaction.
- At most one gnt bit is set at any time.

## Test plan
- Reset, then req=4'b0100 held (defaults, SEED_DEFAULT=8'h01) -> gnt=4'b0100 exactly 9 cycles after the sampling edge, rdata=8'h1C, busy high for 9 cycles.
- req=4'b1111 held continuously from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, spaced 10 cycles apart; rdata 8'h1C then 8'h4B.
- seed_load=1 with seed=8'h00 in IDLE, then req[0] -> LFSR is 8'h01 and rdata=8'h1C. Repeat with seed=8'h1C -> rdata=8'h4B.
- seed_load in the 4th SHIFT cycle of a req[1] transaction -> no gnt, rdata unchanged, ptr unchanged. The re-arbitrated grant goes to requester 1 with the word derived from the new seed.
- rst_n low during SHIFT -> gnt=0, busy=0, rdata=0 immediately. After release, the first word is 8'h1C again.
- req[3] dropped mid-SHIFT with req[0] held -> gnt[3] still pulses, next grant goes to requester 0 (ptr wrapped from 3 to 0).

Source files
------------

// File: rtl/lfsr_sched.sv
// Shared pseudo-random word server: one Fibonacci LFSR time-shared among NREQ
// requesters through a round-robin arbiter; each grant delivers the word after STEPS shifts.
module lfsr_sched #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAP_MASK     = 8'hB8,
  parameter int unsigned      NREQ         = 4,
  parameter int unsigned      STEPS        = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr, ptr_next;
  logic [PTR_W-1:0] winner, winner_next;
  logic [PTR_W-1:0] pick;
  logic             pick_vld;
  logic [PTR_W:0]   scan;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] lfsr, lfsr_next, lfsr_shift, seed_eff;
  logic [NREQ-1:0]  gnt_next;
  logic [WIDTH-1:0] rdata_next;

  assign lfsr_shift = {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)};
  // A zero seed would lock the LFSR up, so it is replaced by the default.
  assign seed_eff   = (seed == '0) ? SEED_DEFAULT : seed;
  assign busy       = (state != IDLE);

  // Walk downward so the last hit is the nearest set request at or above ptr.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    scan     = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      scan = {1'b0, ptr} + (PTR_W+1)'(i);
      if (scan >= (PTR_W+1)'(NREQ)) scan = scan - (PTR_W+1)'(NREQ);
      if (req[scan[PTR_W-1:0]]) begin
        pick     = scan[PTR_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    winner_next = winner;
    cnt_next    = cnt;
    lfsr_next   = lfsr;
    gnt_next    = '0;
    rdata_next  = rdata;
    case (state)
      IDLE: begin
        if (!seed_load && pick_vld) begin
          winner_next = pick;
          cnt_next    = CNT_W'(STEPS - 1);
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (seed_load) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          lfsr_next = lfsr_shift;
          if (cnt == '0) begin
            gnt_next   = NREQ'(1) << winner;
            rdata_next = lfsr_shift;
            state_next = DELIVER;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      DELIVER: begin
        ptr_next   = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Seeding wins over everything; in DELIVER it coexists with the grant.
    if (seed_load) lfsr_next = seed_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr   <= SEED_DEFAULT;
      ptr    <= '0;
      winner <= '0;
      cnt    <= '0;
      gnt    <= '0;
      rdata  <= '0;
    end else begin
      state  <= state_next;
      lfsr   <= lfsr_next;
      ptr    <= ptr_next;
      winner <= winner_next;
      cnt    <= cnt_next;
      gnt    <= gnt_next;
      rdata  <= rdata_next;
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
// Bench for lfsr_sched: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
module tb_lfsr_sched;

  localparam int         NREQ     = 4;
  localparam int         STEPS    = 8;
  localparam logic [7:0] TAPS     = 8'hB8;
  localparam logic [7:0] SEED_DEF = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed = '0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] rdata;
  logic       busy;

  always #5 clk = ~clk;

  lfsr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .rdata     (rdata),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: m_t counts cycles since acceptance (0 = idle, STEPS+1 = grant cycle).
  int         m_t, m_ptr, m_win;
  logic [7:0] m_lfsr, m_start, m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] adv(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], ^(r & TAPS)};
    return r;
  endfunction

  function automatic logic [7:0] eff(input logic [7:0] s);
    return (s == 8'h00) ? SEED_DEF : s;
  endfunction

  task automatic model_reset();
    m_t = 0; m_ptr = 0; m_win = 0; m_lfsr = SEED_DEF; m_rdata = 8'h00; m_start = 8'h00;
  endtask

  task automatic model_edge();
    bit found;
    int idx;
    if (m_t == 0) begin
      if (seed_load) m_lfsr = eff(seed);
      else if (req != 4'b0) begin
        found = 0;
        for (int i = 0; i < NREQ; i++) begin
          idx = (m_ptr + i) % NREQ;
          if (!found && (((req >> idx) & 4'b1) != 4'b0)) begin
            m_win = idx;
            found = 1;
          end
        end
        m_start = m_lfsr;
        m_t = 1;
      end
    end else if (m_t <= STEPS) begin
      if (seed_load) begin
        m_lfsr = eff(seed);
        m_t = 0;
      end else begin
        m_t++;
        if (m_t == STEPS + 1) begin
          m_lfsr  = adv(m_start, STEPS);
          m_rdata = m_lfsr;
        end
      end
    end else begin
      m_ptr = (m_win + 1) % NREQ;
      m_t = 0;
      if (seed_load) m_lfsr = eff(seed);
    end
  endtask

  task automatic check_outputs();
    chk("gnt", {28'b0, gnt}, (m_t == STEPS + 1) ? (32'd1 << m_win) : 32'd0);
    chk("busy", {31'b0, busy}, {31'b0, (m_t != 0)});
    chk("rdata", {24'b0, rdata}, {24'b0, m_rdata});
    chk("onehot", {31'b0, ($countones(gnt) <= 1)}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    seed_load = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", {28'b0, gnt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", {24'b0, rdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int limit, output int n, output int nb);
    bit done = 0;
    n = 0;
    nb = 0;
    while (!done) begin
      step();
      n++;
      if (busy) nb++;
      if (gnt != 4'b0) done = 1;
      else if (n >= limit) begin
        chk("gnt_timeout", {31'b0, |gnt}, 32'd1);
        done = 1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nb;
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Single request from reset
    do_reset();
    req = 4'b0100;
    wait_gnt(30, n, nb);
    chk("s1_lat", n, 9);
    chk("s1_gnt", {28'b0, gnt}, 32'b0100);
    chk("s1_word", {24'b0, rdata}, 32'h1C);
    chk("s1_busy_cycles", nb, 9);
    req = '0;
    step();
    chk("s1_idle", {31'b0, busy}, 32'd0);

    // All requesting: round robin
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(30, n, nb);
      chk($sformatf("s2_gnt%0d", k), {28'b0, gnt}, {28'b0, exp_g[k]});
      chk($sformatf("s2_gap%0d", k), n, (k == 0) ? 9 : 10);
      if (k == 0) chk("s2_word0", {24'b0, rdata}, 32'h1C);
      if (k == 1) chk("s2_word1", {24'b0, rdata}, 32'h4B);
    end
    req = '0;
    repeat (2) step();

    // Seeding in IDLE, zero seed substitution
    do_reset();
    seed_load = 1'b1; seed = 8'h00;
    step();
    seed_load = 1'b0; req = 4'b0001;
    wait_gnt(30, n, nb);
    chk("s3_zero_seed", {24'b0, rdata}, 32'h1C);
    req = '0;
    step();
    seed_load = 1'b1; seed = 8'h1C;
    step();
    seed_load = 1'b0; req = 4'b0001;
    wait_gnt(30, n, nb);
    chk("s3_seed_1c", {24'b0, rdata}, 32'h4B);
    req = '0;
    step();

    // Seed load aborts a transaction in its 4th SHIFT cycle
    do_reset();
    req = 4'b0010;
    repeat (4) step();
    req = 4'b1010;
    seed_load = 1'b1; seed = 8'h5A;
    step();
    seed_load = 1'b0;
    chk("s4_abort_gnt", {28'b0, gnt}, 32'd0);
    chk("s4_abort_busy", {31'b0, busy}, 32'd0);
    chk("s4_abort_rdata", {24'b0, rdata}, 32'd0);
    wait_gnt(30, n, nb);
    chk("s4_regnt", {28'b0, gnt}, 32'b0010);
    chk("s4_word", {24'b0, rdata}, {24'b0, adv(8'h5A, STEPS)});
    req = '0;
    step();

    // Async reset mid-SHIFT
    do_reset();
    req = 4'b0100;
    wait_gnt(30, n, nb);
    chk("s5_first", {24'b0, rdata}, 32'h1C);
    repeat (3) step();
    chk("s5_mid_busy", {31'b0, busy}, 32'd1);
    do_reset();
    req = 4'b0100;
    wait_gnt(30, n, nb);
    chk("s5_after_rst", {24'b0, rdata}, 32'h1C);
    req = '0;
    step();

    // Requester 3 drops mid-SHIFT, pointer wraps to 0
    do_reset();
    req = 4'b1000;
    repeat (4) step();
    req = 4'b0011;
    wait_gnt(30, n, nb);
    chk("s6_gnt3", {28'b0, gnt}, 32'b1000);
    wait_gnt(30, n, nb);
    chk("s6_wrap", {28'b0, gnt}, 32'b0001);
    req = '0;
    step();

    // Random traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      seed_load = ($urandom_range(15) == 0);
      seed = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      step();
    end
    seed_load = 1'b0;
    req = '0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
